// File: rtl/popcount_accum.sv
// -----------------------------------------------------------------------------
// popcount_accum
//
// Accumulates per-nibble population counts into a per-frame result. A frame is
// a run of accepted in_cnt values ending with the accept that carries in_last.
// The frame result is held on the out_* outputs until the consumer takes it.
//
// Handshake (both sides use strict valid/ready):
//   A transfer happens on a rising clk edge where valid & ready are both 1.
//   The producer holds its data stable while valid=1 and ready=0.
//   The ready signals do not depend on the valid signals in the same cycle.
//   Input side:  in_valid / in_ready.   Output side: out_valid / out_ready.
//
// Parameters
//   SUM_W      width of the saturating frame ones-total
//   CNT_W      width of the saturating frame nibble counter
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_cnt     ones count of one nibble (legal 0..4; 5..7 is added as 4 and flags err)
//   in_valid   in_cnt is valid this cycle
//   in_last    in_cnt is the final nibble of the frame (only meaningful with in_valid)
//   in_ready   block can accept in_cnt this cycle (0 while a result is held)
//   out_sum    frame ones-total, saturating
//   out_nib    number of nibbles accepted in the frame, saturating
//   out_par    XOR of all accepted in_cnt[0]
//   out_ovf    out_sum or out_nib clamped during the frame
//   out_err    some accepted in_cnt exceeded 4
//   out_valid  frame result is held on out_*
//   out_ready  consumer takes the result
//   dbg_state  current FSM state (0 IDLE, 1 ACCUM, 2 HOLD)
// -----------------------------------------------------------------------------
module popcount_accum #(
   parameter int SUM_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       in_cnt,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [SUM_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_nib,
   output logic             out_par,
   output logic             out_ovf,
   output logic             out_err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t state;

   logic             accept;
   logic             first;
   logic             cnt_bad;
   logic [2:0]       add;
   logic [SUM_W-1:0] sum_base;
   logic [SUM_W:0]   sum_wide;
   logic             sum_clamp;
   logic [SUM_W-1:0] sum_next;
   logic [CNT_W-1:0] nib_base;
   logic [CNT_W:0]   nib_wide;
   logic             nib_clamp;
   logic [CNT_W-1:0] nib_next;
   logic             par_next;
   logic             ovf_next;
   logic             err_next;

   assign in_ready  = (state != HOLD);
   assign accept    = in_valid & in_ready;
   assign dbg_state = state;

   // Out-of-range counts are treated as a full nibble and flagged.
   assign cnt_bad = (in_cnt > 3'd4);
   assign add     = cnt_bad ? 3'd4 : in_cnt;

   // An accept in IDLE starts a new frame: every accumulator begins from zero,
   // so the same add/clamp path serves both the first and later nibbles.
   assign first    = (state == IDLE);
   assign sum_base = first ? '0 : out_sum;
   assign nib_base = first ? '0 : out_nib;

   // One extra bit catches the carry out; a carry means the true total no
   // longer fits, so the result clamps to all ones.
   assign sum_wide  = {1'b0, sum_base} + (SUM_W+1)'(add);
   assign sum_clamp = sum_wide[SUM_W];
   assign sum_next  = sum_clamp ? '1 : sum_wide[SUM_W-1:0];

   assign nib_wide  = {1'b0, nib_base} + (CNT_W+1)'(1);
   assign nib_clamp = nib_wide[CNT_W];
   assign nib_next  = nib_clamp ? '1 : nib_wide[CNT_W-1:0];

   // Parity uses the raw LSB, even for out-of-range counts.
   assign par_next = (first ? 1'b0 : out_par) ^ in_cnt[0];
   assign ovf_next = (first ? 1'b0 : out_ovf) | sum_clamp | nib_clamp;
   assign err_next = (first ? 1'b0 : out_err) | cnt_bad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_sum   <= '0;
         out_nib   <= '0;
         out_par   <= 1'b0;
         out_ovf   <= 1'b0;
         out_err   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  out_sum   <= sum_next;
                  out_nib   <= nib_next;
                  out_par   <= par_next;
                  out_ovf   <= ovf_next;
                  out_err   <= err_next;
                  out_valid <= in_last;
                  state     <= in_last ? HOLD : ACCUM;
               end
            end
            HOLD: begin
               // Result registers are not written here, so out_* stay stable.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
